// File: rtl/param_gpio_pkg.sv
// Shared constants for the parameter-subsystem GPIO slave: the word
// register map and the width of the per-bit debounce counters.
package param_gpio_pkg;

    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_DIR      = 3'd1;
    localparam logic [2:0] ADDR_IRQ_MASK = 3'd2;
    localparam logic [2:0] ADDR_EDGE_CAP = 3'd3;
    localparam logic [2:0] ADDR_OUTSET   = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR   = 3'd5;
    localparam logic [2:0] ADDR_RISE_EN  = 3'd6;
    localparam logic [2:0] ADDR_FALL_EN  = 3'd7;

    localparam int DB_CNT_W = 16;

endpackage

// File: rtl/param_gpio_ext_filter.sv
// Per-bit input conditioning: synchroniser chain, optional debounce filter
// (PARAM_GPIO_DEBOUNCE_EN), one-cycle delayed copy and edge pulses.
module gpio_bit_filter
    import param_gpio_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic in_bit,
    output logic filt,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   filt_d_reg;

    // Synchroniser chain; bit 0 samples the pad, the top bit is the settled value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], in_bit};
        end
    end

`ifdef PARAM_GPIO_DEBOUNCE_EN
    localparam logic [DB_CNT_W-1:0] DB_LAST = DB_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [DB_CNT_W-1:0] cnt_reg;
    logic                filt_reg;

    // Filtered value only follows the input after it has differed for DEBOUNCE_CYCLES clocks.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_reg  <= '0;
            filt_reg <= 1'b0;
        end else if (sync_reg[SYNC_STAGES-1] == filt_reg) begin
            cnt_reg <= '0;
        end else if (cnt_reg == DB_LAST) begin
            filt_reg <= sync_reg[SYNC_STAGES-1];
            cnt_reg  <= '0;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign filt = filt_reg;
`else
    assign filt = sync_reg[SYNC_STAGES-1];
`endif

    // Previous filtered value, used to form single-cycle edge pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            filt_d_reg <= 1'b0;
        end else begin
            filt_d_reg <= filt;
        end
    end

    assign rise = filt & ~filt_d_reg;
    assign fall = ~filt & filt_d_reg;

endmodule

// File: rtl/param_gpio_ext.sv
// Parametrised Avalon-MM GPIO slave: register file, edge capture with
// write-1-to-clear, registered read mux and level interrupt.
// Optional per-bit input debouncing is built when PARAM_GPIO_DEBOUNCE_EN is defined.
module param_gpio_ext
    import param_gpio_pkg::*;
#(
    parameter int               WIDTH           = 8,
    parameter int               SYNC_STAGES     = 2,
    parameter logic [WIDTH-1:0] RESET_OUT       = '0,
    parameter int               DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic [WIDTH-1:0] oe,
    output logic             irq
);

    logic [WIDTH-1:0] filt;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] edge_hit;
    logic [WIDTH-1:0] wdata;
    logic             wr_en;

    logic [WIDTH-1:0] out_reg, out_next;
    logic [WIDTH-1:0] dir_reg, dir_next;
    logic [WIDTH-1:0] mask_reg, mask_next;
    logic [WIDTH-1:0] cap_reg, cap_next;
    logic [WIDTH-1:0] rise_en_reg, rise_en_next;
    logic [WIDTH-1:0] fall_en_reg, fall_en_next;
    logic [WIDTH-1:0] cap_clr;
    logic [31:0]      readdata_reg, readdata_next;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            gpio_bit_filter #(
                .SYNC_STAGES     (SYNC_STAGES),
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_filter (
                .clk     (clk),
                .reset_n (reset_n),
                .in_bit  (in_port[gi]),
                .filt    (filt[gi]),
                .rise    (rise[gi]),
                .fall    (fall[gi])
            );
        end
        if (WIDTH < 32) begin : g_unused
            logic unused_wdata;
            assign unused_wdata = ^writedata[31:WIDTH];
        end
    endgenerate

    assign wr_en    = chipselect & ~write_n;
    assign wdata    = writedata[WIDTH-1:0];
    assign edge_hit = (rise & rise_en_reg) | (fall & fall_en_reg);

    // Register writes; a new edge overrides a coincident W1C clear of the same bit.
    always_comb begin
        out_next     = out_reg;
        dir_next     = dir_reg;
        mask_next    = mask_reg;
        rise_en_next = rise_en_reg;
        fall_en_next = fall_en_reg;
        cap_clr      = '0;
        if (wr_en) begin
            case (address)
                ADDR_DATA:     out_next     = wdata;
                ADDR_DIR:      dir_next     = wdata;
                ADDR_IRQ_MASK: mask_next    = wdata;
                ADDR_EDGE_CAP: cap_clr      = wdata;
                ADDR_OUTSET:   out_next     = out_reg | wdata;
                ADDR_OUTCLR:   out_next     = out_reg & ~wdata;
                ADDR_RISE_EN:  rise_en_next = wdata;
                ADDR_FALL_EN:  fall_en_next = wdata;
                default:       ;
            endcase
        end
        cap_next = (cap_reg & ~cap_clr) | edge_hit;
    end

    // Read mux, evaluated every cycle from the current address.
    always_comb begin
        readdata_next = '0;
        case (address)
            ADDR_DATA:     readdata_next[WIDTH-1:0] = (out_reg & dir_reg) | (filt & ~dir_reg);
            ADDR_DIR:      readdata_next[WIDTH-1:0] = dir_reg;
            ADDR_IRQ_MASK: readdata_next[WIDTH-1:0] = mask_reg;
            ADDR_EDGE_CAP: readdata_next[WIDTH-1:0] = cap_reg;
            ADDR_RISE_EN:  readdata_next[WIDTH-1:0] = rise_en_reg;
            ADDR_FALL_EN:  readdata_next[WIDTH-1:0] = fall_en_reg;
            default:       readdata_next = '0;
        endcase
    end

    // Register file, capture bits and read data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_reg      <= RESET_OUT;
            dir_reg      <= '0;
            mask_reg     <= '0;
            cap_reg      <= '0;
            rise_en_reg  <= '0;
            fall_en_reg  <= '0;
            readdata_reg <= '0;
        end else begin
            out_reg      <= out_next;
            dir_reg      <= dir_next;
            mask_reg     <= mask_next;
            cap_reg      <= cap_next;
            rise_en_reg  <= rise_en_next;
            fall_en_reg  <= fall_en_next;
            readdata_reg <= readdata_next;
        end
    end

    assign out_port = out_reg;
    assign oe       = dir_reg;
    assign readdata = readdata_reg;
    assign irq      = |(cap_reg & mask_reg);

endmodule

// File: tb/tb_param_gpio_ext.sv
// Self-checking bench for param_gpio_ext: directed register/edge scenarios
// followed by randomized bus and pad traffic, all compared every cycle
// against a behavioural model of the register map and input conditioning.
module tb_param_gpio_ext;

    localparam int        W = 8;
    localparam int        S = 2;
    localparam int        D = 16;
    localparam logic [7:0] R = 8'hA5;
`ifdef PARAM_GPIO_DEBOUNCE_EN
    localparam int LAT = S + D + 1;
`else
    localparam int LAT = S + 1;
`endif
    localparam int SETTLE = S + D + 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  address = 3'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'h0;
    logic [31:0] readdata;
    logic [7:0]  in_port = 8'h00;
    logic [7:0]  out_port;
    logic [7:0]  oe;
    logic        irq;

    int checks = 0;
    int errors = 0;
    logic [7:0] pin = 8'h00;

    param_gpio_ext #(
        .WIDTH           (W),
        .SYNC_STAGES     (S),
        .RESET_OUT       (R),
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .in_port    (in_port),
        .out_port   (out_port),
        .oe         (oe),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    // Behavioural model
    logic [7:0]  m_out, m_dir, m_mask, m_cap, m_rise, m_fall, m_filt, m_filt_d;
    logic [31:0] m_rd;
    logic [7:0]  m_hist [S];
    int          m_run [W];
    logic [7:0]  t_sync, t_edges, t_clr, t_wd;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_out = R; m_dir = 0; m_mask = 0; m_cap = 0; m_rise = 0; m_fall = 0;
            m_filt = 0; m_filt_d = 0; m_rd = 0;
            for (int k = 0; k < S; k++) m_hist[k] = 0;
            for (int b = 0; b < W; b++) m_run[b] = 0;
        end else begin
            t_sync  = m_hist[S-1];
            t_edges = (m_filt & ~m_filt_d & m_rise) | (~m_filt & m_filt_d & m_fall);
            t_wd    = writedata[7:0];
            t_clr   = 0;
            case (address)
                3'd0: m_rd = {24'h0, (m_out & m_dir) | (m_filt & ~m_dir)};
                3'd1: m_rd = {24'h0, m_dir};
                3'd2: m_rd = {24'h0, m_mask};
                3'd3: m_rd = {24'h0, m_cap};
                3'd6: m_rd = {24'h0, m_rise};
                3'd7: m_rd = {24'h0, m_fall};
                default: m_rd = 0;
            endcase
            if (chipselect && !write_n) begin
                case (address)
                    3'd0: m_out  = t_wd;
                    3'd1: m_dir  = t_wd;
                    3'd2: m_mask = t_wd;
                    3'd3: t_clr  = t_wd;
                    3'd4: m_out  = m_out | t_wd;
                    3'd5: m_out  = m_out & ~t_wd;
                    3'd6: m_rise = t_wd;
                    3'd7: m_fall = t_wd;
                    default: ;
                endcase
            end
            m_cap    = (m_cap & ~t_clr) | t_edges;
            m_filt_d = m_filt;
            for (int k = S - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
            m_hist[0] = in_port;
`ifdef PARAM_GPIO_DEBOUNCE_EN
            // filtered bit follows once the settled input has disagreed for D consecutive clocks
            for (int b = 0; b < W; b++) begin
                if (t_sync[b] != m_filt[b]) begin
                    m_run[b]++;
                    if (m_run[b] == D) begin
                        m_filt[b] = t_sync[b];
                        m_run[b]  = 0;
                    end
                end else begin
                    m_run[b] = 0;
                end
            end
`else
            m_filt = m_hist[S-1];
`endif
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("out_port", {24'h0, out_port}, {24'h0, m_out});
        check("oe", {24'h0, oe}, {24'h0, m_dir});
        check("irq", {31'h0, irq}, {31'h0, |(m_cap & m_mask)});
        check("readdata", readdata, m_rd);
    endtask

    task automatic drive(input logic cs, input logic wn, input logic [2:0] a, input logic [31:0] wd);
        chipselect = cs; write_n = wn; address = a; writedata = wd; in_port = pin;
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        $display("txn write addr=%0d data=%h pin=%h", a, d, pin);
        drive(1'b1, 1'b0, a, d);
    endtask

    task automatic rd(input logic [2:0] a);
        drive(1'b0, 1'b1, a, 32'h0);
        $display("txn read  addr=%0d data=%h pin=%h", a, readdata, pin);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b1, address, 32'h0);
    endtask

    initial begin
        int hold;
        // Reset state
        pin = 8'h3C;
        idle(3);
        check("rst_out_port", {24'h0, out_port}, 32'hA5);
        check("rst_oe", {24'h0, oe}, 32'h0);
        check("rst_irq", {31'h0, irq}, 32'h0);
        check("rst_readdata", readdata, 32'h0);
        reset_n = 1'b1;
        idle(SETTLE);
        rd(3'd0);
        check("data_input_3c", readdata, 32'h3C);

        // Mixed-direction DATA readback, OUTSET, OUTCLR
        wr(3'd1, 32'hF0);
        wr(3'd0, 32'h5A);
        pin = 8'h0F;
        idle(SETTLE);
        rd(3'd0);
        check("data_mixed", readdata, 32'h5F);
        wr(3'd4, 32'h01);
        check("outset", {24'h0, out_port}, 32'h5B);
        wr(3'd5, 32'h50);
        check("outclr", {24'h0, out_port}, 32'h0B);

        // Edge enables and capture latency
        pin = 8'h00;
        idle(SETTLE);
        wr(3'd6, 32'h01);
        wr(3'd7, 32'h02);
        wr(3'd2, 32'h03);
        wr(3'd3, 32'hFF);
        pin = 8'h01;
        for (int i = 1; i <= LAT; i++) begin
            idle(1);
            check("rise_latency_irq", {31'h0, irq}, {31'h0, i == LAT});
        end
        idle(3);
        pin = 8'h00;
        idle(SETTLE);
        rd(3'd3);
        check("cap_rise_only", readdata, 32'h01);
        pin = 8'h02;
        idle(SETTLE);
        pin = 8'h00;
        idle(SETTLE);
        rd(3'd3);
        check("cap_fall", readdata, 32'h03);

        // Individual W1C clears
        wr(3'd3, 32'h01);
        check("w1c_irq_hold", {31'h0, irq}, 32'h1);
        rd(3'd3);
        check("w1c_bit0", readdata, 32'h02);
        wr(3'd3, 32'h02);
        check("w1c_irq_drop", {31'h0, irq}, 32'h0);
        rd(3'd3);
        check("w1c_all", readdata, 32'h00);

        // Clear and new edge on the same bit in the same cycle
        pin = 8'h01;
        idle(LAT - 1);
        wr(3'd3, 32'h01);
        check("collide_irq", {31'h0, irq}, 32'h1);
        rd(3'd3);
        check("collide_cap", readdata, 32'h01);
        pin = 8'h00;
        idle(SETTLE);
        wr(3'd3, 32'hFF);

        // Randomized traffic, with one asynchronous reset in the middle
        hold = 0;
        for (int n = 0; n < 600; n++) begin
            if (hold == 0) begin
                pin  = 8'($urandom);
                hold = $urandom_range(1, 25);
            end
            hold--;
            if ($urandom_range(0, 3) == 0) wr(3'($urandom_range(0, 7)), $urandom);
            else rd(3'($urandom_range(0, 7)));
            if (n == 300) begin
                reset_n = 1'b0;
                #1;
                check_all();
                check("midrst_out_port", {24'h0, out_port}, 32'hA5);
                check("midrst_irq", {31'h0, irq}, 32'h0);
                idle(2);
                reset_n = 1'b1;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
